// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO stage: IO window decode, LED register, switch synchroniser/debouncer and read mux.
// Optional switch-event status flag at STAT_ADDR is built only when SW_EVENT_EN is defined.
module io_mmio_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] LED_ADDR        = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR         = 32'hFFFFFC70,
    parameter logic [31:0] STAT_ADDR       = 32'hFFFFFC74
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch_raw,
    output logic        io_sel,
    output logic [31:0] rdata,
    output logic [7:0]  led
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             hit_led;
    logic             hit_sw;
    logic             hit_stat;
    logic [7:0]       sync_s1;
    logic [7:0]       sync_s2;
    logic [7:0]       candidate;
    logic [7:0]       sw_stable;
    logic [CNT_W-1:0] counter;
    logic             sw_update;

    // Byte offset within a word is irrelevant to every match.
    assign io_sel   = (addr[31:10] == 22'h3FFFFF);
    assign hit_led  = (addr[31:2] == LED_ADDR[31:2]);
    assign hit_sw   = (addr[31:2] == SW_ADDR[31:2]);
    assign hit_stat = (addr[31:2] == STAT_ADDR[31:2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= 8'h00;
        end else if (mem_write && hit_led) begin
            led <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_s1 <= 8'h00;
            sync_s2 <= 8'h00;
        end else begin
            sync_s1 <= switch_raw;
            sync_s2 <= sync_s1;
        end
    end

    assign sw_update = (sync_s2 == candidate) && (counter == CNT_MAX) && (candidate != sw_stable);

    // The whole vector is one candidate; any bit moving restarts the stability count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            candidate <= 8'h00;
            counter   <= '0;
            sw_stable <= 8'h00;
        end else if (sync_s2 != candidate) begin
            candidate <= sync_s2;
            counter   <= '0;
        end else if (sw_update) begin
            sw_stable <= candidate;
        end else if (counter < CNT_MAX) begin
            counter <= counter + CNT_W'(1);
        end
    end

`ifdef SW_EVENT_EN
    logic sw_event;

    // Set has priority so a change landing on the clearing read is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_event <= 1'b0;
        end else if (sw_update) begin
            sw_event <= 1'b1;
        end else if (mem_read && hit_stat) begin
            sw_event <= 1'b0;
        end
    end
`endif

    always_comb begin
        rdata = 32'h0000_0000;
        if (hit_sw) begin
            rdata = {24'h000000, sw_stable};
        end else if (hit_led) begin
            rdata = {24'h000000, led};
`ifdef SW_EVENT_EN
        end else if (hit_stat) begin
            rdata = {31'h00000000, sw_event};
`endif
        end
    end

    logic unused_sigs;
    assign unused_sigs = &{1'b0, wdata[31:8], mem_read, hit_stat};

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl with DEBOUNCE_CYCLES=4; expectations flow through a scoreboard queue.
module tb_io_mmio_ctrl;

    localparam int          DB        = 4;
    localparam logic [31:0] LED_ADDR  = 32'hFFFFFC60;
    localparam logic [31:0] SW_ADDR   = 32'hFFFFFC70;
    localparam logic [31:0] STAT_ADDR = 32'hFFFFFC74;
`ifdef SW_EVENT_EN
    localparam logic [31:0] EV_ON = 32'h1;
`else
    localparam logic [31:0] EV_ON = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  switch_raw;
    logic        io_sel;
    logic [31:0] rdata;
    logic [7:0]  led;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    io_mmio_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .switch_raw(switch_raw),
        .io_sel    (io_sel),
        .rdata     (rdata),
        .led       (led)
    );

    task automatic set_bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_read  = r;
        mem_write = w;
        addr      = a;
        wdata     = d;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        switch_raw = 8'hFF;
        set_bus(1'b1, 1'b1, LED_ADDR, 32'h000000FF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp_q.push_back(32'h0);
            exp_v = exp_q.pop_front();
            checks++;
            if ({24'h0, led} !== exp_v) begin
                errors++;
                $display("FAIL reset_led got %h expected %h", led, exp_v[7:0]);
            end
            addr = SW_ADDR;
            exp_q.push_back(32'h0);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL reset_sw_read got %h expected %h", rdata, exp_v);
            end
            addr = LED_ADDR;
        end
        @(negedge clk);
        switch_raw = 8'h00;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_led;
        @(negedge clk);
        set_bus(1'b0, 1'b1, LED_ADDR, 32'h123456A5);
        #1;
        checks++;
        if (io_sel !== 1'b1) begin
            errors++;
            $display("FAIL led_io_sel got %b expected 1", io_sel);
        end
        exp_q.push_back(32'h000000A5);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b0, LED_ADDR, 32'h0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ({24'h0, led} !== exp_v) begin
            errors++;
            $display("FAIL led_value got %h expected %h", led, exp_v[7:0]);
        end
        checks++;
        if (rdata !== exp_v) begin
            errors++;
            $display("FAIL led_readback got %h expected %h", rdata, exp_v);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        set_bus(1'b1, 1'b0, SW_ADDR, 32'h0);
        switch_raw = 8'h81;
        repeat (3) @(posedge clk);
        @(negedge clk);
        switch_raw = 8'h00;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(32'h0);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL glitch_cycle%0d got %h expected %h", i, rdata, exp_v);
            end
        end
    endtask

    task automatic test_debounce;
        @(negedge clk);
        set_bus(1'b1, 1'b0, SW_ADDR, 32'h0);
        switch_raw = 8'h3C;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL debounce_pre got %h expected %h", rdata, 32'h0);
        end
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back((k >= DB + 3) ? 32'h0000003C : 32'h0);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL debounce_edge%0d got %h expected %h", k, rdata, exp_v);
            end
        end
    endtask

    task automatic test_decode;
        @(negedge clk);
        set_bus(1'b0, 1'b1, SW_ADDR, 32'h000000FF);
        exp_q.push_back(32'h0000003C);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b0, SW_ADDR, 32'h0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rdata !== exp_v) begin
            errors++;
            $display("FAIL decode_sw_write got %h expected %h", rdata, exp_v);
        end
        @(negedge clk);
        set_bus(1'b0, 1'b1, 32'h00000060, 32'h00000000);
        #1;
        checks++;
        if (io_sel !== 1'b0) begin
            errors++;
            $display("FAIL decode_io_sel_low got %b expected 0", io_sel);
        end
        exp_q.push_back(32'h000000A5);
        @(posedge clk); #1;
        set_bus(1'b0, 1'b1, STAT_ADDR, 32'h000000FF);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ({24'h0, led} !== exp_v) begin
            errors++;
            $display("FAIL decode_led_kept got %h expected %h", led, exp_v[7:0]);
        end
        set_bus(1'b1, 1'b0, 32'hFFFFFC64, 32'h0);
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_unmapped got %h expected %h", rdata, 32'h0);
        end
        addr = 32'hFFFFFC63;
        #1;
        checks++;
        if (rdata !== 32'h000000A5) begin
            errors++;
            $display("FAIL decode_byte_offset got %h expected %h", rdata, 32'h000000A5);
        end
        addr = 32'hFFFFFC00;
        #1;
        checks++;
        if (io_sel !== 1'b1) begin
            errors++;
            $display("FAIL decode_window_low got %b expected 1", io_sel);
        end
        addr = 32'hFFFFFBFC;
        #1;
        checks++;
        if (io_sel !== 1'b0) begin
            errors++;
            $display("FAIL decode_below_window got %b expected 0", io_sel);
        end
    endtask

    task automatic test_event;
        @(negedge clk);
        set_bus(1'b1, 1'b0, STAT_ADDR, 32'h0);
        #1;
        checks++;
        if (rdata !== EV_ON) begin
            errors++;
            $display("FAIL event_set got %h expected %h", rdata, EV_ON);
        end
        @(posedge clk); #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL event_cleared got %h expected %h", rdata, 32'h0);
        end
        @(negedge clk);
        set_bus(1'b0, 1'b0, STAT_ADDR, 32'h0);
        switch_raw = 8'h00;
        repeat (DB + 2) @(posedge clk);
        @(negedge clk);
        mem_read = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL event_pre_coincide got %h expected %h", rdata, 32'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (rdata !== EV_ON) begin
            errors++;
            $display("FAIL event_set_wins got %h expected %h", rdata, EV_ON);
        end
        mem_read = 1'b0;
        addr     = SW_ADDR;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL event_sw_value got %h expected %h", rdata, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        @(negedge clk);
        set_bus(1'b1, 1'b1, LED_ADDR, 32'h0000005A);
        #1;
        checks++;
        if (rdata !== 32'h000000A5) begin
            errors++;
            $display("FAIL rw_same_pre_edge got %h expected %h", rdata, 32'h000000A5);
        end
        exp_q.push_back(32'h0000005A);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rdata !== exp_v) begin
            errors++;
            $display("FAIL rw_same_post_edge got %h expected %h", rdata, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wdata = {24'h0, vals[i]};
            exp_q.push_back({24'h0, vals[i]});
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if ({24'h0, led} !== exp_v) begin
                errors++;
                $display("FAIL b2b_write%0d got %h expected %h", i, led, exp_v[7:0]);
            end
        end
        @(negedge clk);
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        switch_raw = 8'h00;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_led();
        test_glitch();
        test_debounce();
        test_decode();
        test_event();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
